comparator_n_bit_serial: RTL and testbench

COMPARATOR_N_BIT_SERIAL -- requirements
Module: comparator_n_bit_serial

---
 rtl/comparator_n_bit_serial.sv | 139 +++++++++++++
 tb/tb_comparator_n_bit_serial.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/comparator_n_bit_serial.sv
// Bit-serial magnitude comparator.
// Walks the latched operands one bit per cycle, MSB first, and reports
// equal / greater / less as registered one-hot results. The MSB is the sign
// bit in two's-complement mode, so its decision is inverted there. With
// EARLY_EXIT=1 the scan stops at the first differing bit; with EARLY_EXIT=0
// every bit is visited so the latency does not depend on the data.
//
// Handshake: start is sampled on a rising clk edge and is accepted only in
// IDLE or DONE. A, B and signed_mode are captured on that same edge; changes
// afterwards do not affect the compare in progress. busy is high for the
// whole scan, and done is a single-cycle pulse that marks the results valid.
// The results then hold until the next accepted start.
module comparator_n_bit_serial #(
    parameter int WIDTH      = 8,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_equals_B,
    output logic             A_greater_B,
    output logic             A_less_B,
    output logic [1:0]       o_dbg_state
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IW-1:0]    r_idx;
    logic             r_decided;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_diff;
    logic             w_msb;
    logic             w_last;
    logic             w_a_wins;

    // Decision for the bit pair currently under the index.
    always_comb begin
        w_a_bit  = r_a[r_idx];
        w_b_bit  = r_b[r_idx];
        w_diff   = w_a_bit ^ w_b_bit;
        w_msb    = (r_idx == IW'(WIDTH - 1));
        w_last   = (r_idx == '0);
        // A sign bit of 1 means A is the negative (smaller) operand.
        w_a_wins = (r_signed && w_msb) ? ~w_a_bit : w_a_bit;
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a       <= A;
                        r_b       <= B;
                        r_signed  <= signed_mode;
                        r_idx     <= IW'(WIDTH - 1);
                        r_decided <= 1'b0;
                        r_eq      <= 1'b0;
                        r_gt      <= 1'b0;
                        r_lt      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_COMPARE;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_COMPARE: begin
                    r_idx <= r_idx - 1'b1;
                    // Only the first differing bit decides; later ones are ignored.
                    if (w_diff && !r_decided) begin
                        r_gt      <= w_a_wins;
                        r_lt      <= ~w_a_wins;
                        r_decided <= 1'b1;
                    end
                    if ((EARLY_EXIT != 0) && w_diff) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_last) begin
                        if (!r_decided && !w_diff) begin
                            r_eq <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign A_equals_B  = r_eq;
    assign A_greater_B = r_gt;
    assign A_less_B    = r_lt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_comparator_n_bit_serial.sv
// Directed bench for comparator_n_bit_serial: one early-exit instance and one
// full-scan instance share clock, reset and stimulus.
module tb_comparator_n_bit_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         busy1, done1, eq1, gt1, lt1;
  logic [1:0]   st1;
  logic         busy0, done0, eq0, gt0, lt0;
  logic [1:0]   st0;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  comparator_n_bit_serial #(.WIDTH(W), .EARLY_EXIT(1)) u_ee1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A(a), .B(b), .busy(busy1), .done(done1),
    .A_equals_B(eq1), .A_greater_B(gt1), .A_less_B(lt1),
    .o_dbg_state(st1)
  );

  comparator_n_bit_serial #(.WIDTH(W), .EARLY_EXIT(0)) u_ee0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .A(a), .B(b), .busy(busy0), .done(done0),
    .A_equals_B(eq0), .A_greater_B(gt0), .A_less_B(lt0),
    .o_dbg_state(st0)
  );

  // scoreboard: expected values pushed by the stimulus, popped at compare time
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_q(input string tag, input logic [63:0] got);
    logic [63:0] e;
    e = exp_q.pop_front();
    check(tag, got, e);
  endtask

  // driver: present operands with start for one edge; returns in the cycle after E0
  task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic s);
    @(negedge clk);
    a = va; b = vb; signed_mode = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // count negedges until the selected instance shows done; n = k means cycle after E(k)
  task automatic wait_done(input bit ee1, output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!(ee1 ? done1 : done0) && n < 64) begin
      if (ee1 ? busy1 : busy0) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int n, bc, n2, pulses;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_res", {eq1, gt1, lt1, eq0, gt0, lt0}, 0);
    check("rst_state", st1, 0);
    rst = 1'b0;

    // unsigned equal A5/A5: 8 busy cycles, done after E8
    drive_start(8'hA5, 8'hA5, 1'b0);
    exp_q.push_back(8); exp_q.push_back(8); exp_q.push_back(3'b100);
    wait_done(1, n, bc);
    check_q("eq_latency", n);
    check_q("eq_busy_cycles", bc);
    check_q("eq_result", {eq1, gt1, lt1});
    check("eq_ee0_result", {eq0, gt0, lt0}, 3'b100);
    @(negedge clk);
    check("eq_done_one_cycle", done1, 0);
    check("eq_hold_idle", {eq1, gt1, lt1}, 3'b100);
    settle();

    // unsigned 80 vs 7F: early exit after E1; full scan still takes 8
    drive_start(8'h80, 8'h7F, 1'b0);
    wait_done(1, n, bc);
    check("u80_latency", n, 1);
    check("u80_result", {eq1, gt1, lt1}, 3'b010);
    wait_done(0, n2, bc);
    check("u80_ee0_latency", n + n2, 8);
    check("u80_ee0_result", {eq0, gt0, lt0}, 3'b010);
    check("u80_hold", {eq1, gt1, lt1}, 3'b010);
    settle();

    // signed -128 vs +127: less after one compare cycle
    drive_start(8'h80, 8'h7F, 1'b1);
    wait_done(1, n, bc);
    check("s80_latency", n, 1);
    check("s80_result", {eq1, gt1, lt1}, 3'b001);
    settle();
    check("s80_ee0_result", {eq0, gt0, lt0}, 3'b001);

    // signed -1 vs -2: decided at bit 0
    drive_start(8'hFF, 8'hFE, 1'b1);
    wait_done(1, n, bc);
    check("sff_latency", n, 8);
    check("sff_result", {eq1, gt1, lt1}, 3'b010);
    settle();

    // full scan 03 vs 02, with a start pulse at E3 carrying A=00 that must be ignored
    drive_start(8'h03, 8'h02, 1'b0);
    n = 0;
    while (!done0 && n < 64) begin
      if (n == 2) begin
        start = 1'b1; a = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (n >= 64) check("ee0_timeout", 64'd0, 64'd1);
    check("ee0_latency", n, 8);
    check("ee0_result", {eq0, gt0, lt0}, 3'b010);
    check("ee0_busy_at_done", busy0, 0);
    check("ee1_ignore_result", {eq1, gt1, lt1}, 3'b010);
    @(negedge clk);
    check("ee0_no_restart", busy0, 0);
    settle();

    // reset during cycle 4 of a compare: outputs clear immediately, no done afterwards
    drive_start(8'hA5, 8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy1, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {busy1, busy0}, 0);
    check("mid_rst_done", {done1, done0}, 0);
    check("mid_rst_res", {eq1, gt1, lt1, eq0, gt0, lt0}, 0);
    check("mid_rst_state", st1, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 || done0) pulses++;
    end
    check("rst_no_done", pulses, 0);

    // back-to-back: start held in the DONE cycle with 01 vs 02
    drive_start(8'h80, 8'h7F, 1'b0);
    wait_done(1, n, bc);
    check("b2b_first_latency", n, 1);
    a = 8'h01; b = 8'h02; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_no_gap", busy1, 1);
    check("b2b_cleared", {done1, eq1, gt1, lt1}, 0);
    wait_done(1, n, bc);
    check("b2b_latency", n, 7);
    check("b2b_result", {eq1, gt1, lt1}, 3'b001);
    settle();

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
